div_iter: RTL and testbench
===========================

# div_iter

Iterative radix-2 restoring divider for the execute stage, directly downstream of the main decoder. When the decoder emits `DIV_CONTROL` or `DIVU_CONTROL` with `hilo_we = 2'b11`, execute raises `start` and this block takes over. It stalls the pipeline for a fixed WIDTH+2 cycles, then presents remainder and quotient for the HI/LO write. Exception and flush logic can annul it at any cycle.

## Interface
Parameters:
- `WIDTH`, default 32: operand and result width.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `start`  in  1  request a divide; held high by execute while stalled.
- `is_signed`  in  1  1 = DIV, 0 = DIVU; sampled with `start`.
- `dividend`  in  WIDTH  rs value; sampled with `start`.
- `divisor`  in  WIDTH  rt value; sampled with `start`.
- `annul`  in  1  flush or exception; cancels any operation in flight.
- `stall`  out  1  holds IF/ID/EX while a divide is pending.
- `valid`  out  1  one-cycle pulse; `result` is correct in that cycle.
- `result`  out  2*WIDTH  {remainder → HI, quotient → LO}.

## Operation
States: IDLE, RUN, FIX, DONE.
- **IDLE:** if `start` and not `annul`, capture on the edge:
  - |dividend| and |divisor| (absolute value only when `is_signed`).
  - Sign of quotient = XOR of operand MSBs, sign of remainder = dividend MSB (signed only).
  - Divide-by-zero flag = divisor == 0.
  - Clear the iteration counter; go to RUN.
- **RUN:** one restoring step per cycle.
  - Partial remainder (WIDTH+1 bits) shifts left, taking in the next dividend MSB.
  - Trial-subtract the divisor; if non-negative, keep the difference and shift a 1 into the quotient, else shift in a 0.
  - After WIDTH steps (counter == WIDTH-1 on the edge), go to FIX.
- **FIX:** apply the signs by two's-complement negation, then load `result`; go to DONE.
  - Divide by zero: quotient = all ones, remainder = original dividend, regardless of `is_signed`.
  - Overflow, -2^(WIDTH-1) / -1: no special case. The natural result is quotient 0x8000_0000, remainder 0.
- **DONE:** `valid` = 1, `stall` = 0; unconditionally return to IDLE.
  - `start` is ignored in DONE, because the same instruction is still in EX.
- **Annul:** any cycle with `annul` = 1 forces IDLE on the next edge.
  - No `valid` is produced; `result` keeps its previous value.
  - `annul` together with `start` in IDLE: the request is ignored.
- **Hold:** `result` is unchanged except when loaded in FIX.

## Timing
- **Reset:** asynchronous on `resetn` low, mid-operation included.
  - state = IDLE, counter = 0, `result` = 0, `valid` = 0, `stall` = 0.
  - Internal operand, sign and flag registers = 0.
- **`stall`:** combinational, `(IDLE & start & ~annul) | RUN | FIX`.
  - It is high in the request cycle itself, so the pipeline freezes immediately.
- **Latency:** `start` accepted in cycle 0 → RUN in cycles 1..WIDTH → FIX in cycle WIDTH+1 → `valid` in cycle WIDTH+2 (34 for WIDTH=32).
  - Fixed latency, independent of operand values.
- **Back-to-back:** a new `start` is accepted in the IDLE cycle right after DONE, so there is one bubble minimum between divides.
- **Registered outputs:** `valid` and `result` are registered; `stall` is the only combinational output.

## Structure
- `DIV_CONTROL` and `DIVU_CONTROL` stay in the shared `defines.h`, and execute derives `start` from them.
- The state encoding (2-bit) and `WIDTH` default are local parameters of this module. They are not shared.
- Single module, no sub-modules.
  - The negate/abs helper is one `function` inside the module. A separate instance is not warranted.

## Test plan
- **Unsigned:** DIVU 100 / 7, start in cycle 0 → `stall` high cycles 0–33, `valid` in cycle 34 only, `result` = {32'd2, 32'd14}.
- **Signed:** DIV -7 / 2 → quotient 0xFFFF_FFFD, remainder 0xFFFF_FFFF; DIV 7 / -2 → quotient 0xFFFF_FFFD, remainder 0x0000_0001.
- **Edge operands:**
  - DIV 0x8000_0000 / 0xFFFF_FFFF → {0, 0x8000_0000}.
  - DIVU 0x1234_5678 / 0 → {0x1234_5678, 0xFFFF_FFFF}.
- **Annul:** `annul` pulsed in cycle 10 → `stall` low from cycle 11, no `valid`, `result` unchanged; a fresh DIVU 9 / 3 starting in cycle 12 → `valid` in cycle 46 with {0, 3}.
- **Reset mid-operation:** `resetn` low in cycle 20 → `stall`, `valid` and `result` zero immediately (asynchronous); after release, idle until `start`.
- **Back-to-back:** `start` held through DONE (no second capture), then a second DIV in the following IDLE cycle → exactly two `valid` pulses, 35 cycles apart.

Source files
------------

// File: rtl/div_iter_pkg.sv
// Shared operation-kind type for the iterative divider.
package div_iter_pkg;

  // Operation kind as sampled from the is_signed input: DIVU or DIV.
  typedef enum logic {
    OP_DIVU = 1'b0,
    OP_DIV  = 1'b1
  } div_op_e;

endpackage

// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider with a fixed WIDTH+2 cycle latency.
// The divide works on magnitudes. Signs are applied in a final fix-up cycle.
// The result is {remainder, quotient}, which maps to {HI, LO}.
module div_iter
  import div_iter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   dividend,
  input  logic [WIDTH-1:0]   divisor,
  input  logic               annul,
  output logic               stall,
  output logic               valid,
  output logic [2*WIDTH-1:0] result
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  // Two's-complement negation. It is used both for the absolute value and
  // for re-applying the signs of the results.
  function automatic logic [WIDTH-1:0] f_neg(input logic [WIDTH-1:0] a);
    return ~a + WIDTH'(1);
  endfunction

  state_e             r_state;
  logic [CW-1:0]      r_cnt;
  logic [WIDTH-1:0]   r_quot;        // starts as |dividend|; quotient bits shift in at the LSB
  logic [WIDTH-1:0]   r_rem;         // partial remainder; always below the divisor
  logic [WIDTH-1:0]   r_divisor;     // |divisor|
  logic [WIDTH-1:0]   r_dividend;    // original dividend, for the divide-by-zero remainder
  logic               r_q_neg;
  logic               r_r_neg;
  logic               r_dz;
  logic               r_valid;
  logic [2*WIDTH-1:0] r_result;

  div_op_e            w_op;
  logic [WIDTH:0]     w_shift;
  logic [WIDTH:0]     w_sub;
  logic               w_ge;
  logic [WIDTH-1:0]   w_quot_fix;
  logic [WIDTH-1:0]   w_rem_fix;

  assign w_op = div_op_e'(is_signed);

  // Restoring step. The shifted remainder is below twice the divisor, so the
  // MSB of the trial difference is a reliable borrow flag.
  assign w_shift = {r_rem, r_quot[WIDTH-1]};
  assign w_sub   = w_shift - {1'b0, r_divisor};
  assign w_ge    = ~w_sub[WIDTH];

  // Sign fix-up. Divide by zero overrides the computed quotient and remainder.
  assign w_quot_fix = r_dz ? {WIDTH{1'b1}} : (r_q_neg ? f_neg(r_quot) : r_quot);
  assign w_rem_fix  = r_dz ? r_dividend    : (r_r_neg ? f_neg(r_rem)  : r_rem);

  // The pipeline freezes in the request cycle itself, and stays frozen until DONE.
  assign stall  = ((r_state == S_IDLE) & start & ~annul) |
                  (r_state == S_RUN) | (r_state == S_FIX);
  assign valid  = r_valid;
  assign result = r_result;

  // Divider sequencer: capture, WIDTH restoring steps, sign fix-up, one-cycle done.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_quot     <= '0;
      r_rem      <= '0;
      r_divisor  <= '0;
      r_dividend <= '0;
      r_q_neg    <= 1'b0;
      r_r_neg    <= 1'b0;
      r_dz       <= 1'b0;
      r_valid    <= 1'b0;
      r_result   <= '0;
    end else begin
      r_valid <= 1'b0;
      if (annul) begin
        r_state <= S_IDLE;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start) begin
              r_quot     <= (w_op == OP_DIV && dividend[WIDTH-1]) ? f_neg(dividend) : dividend;
              r_divisor  <= (w_op == OP_DIV && divisor[WIDTH-1])  ? f_neg(divisor)  : divisor;
              r_dividend <= dividend;
              r_q_neg    <= (w_op == OP_DIV) & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
              r_r_neg    <= (w_op == OP_DIV) & dividend[WIDTH-1];
              r_dz       <= (divisor == '0);
              r_rem      <= '0;
              r_cnt      <= '0;
              r_state    <= S_RUN;
            end
          end
          S_RUN: begin
            r_rem  <= w_ge ? w_sub[WIDTH-1:0] : w_shift[WIDTH-1:0];
            r_quot <= {r_quot[WIDTH-2:0], w_ge};
            if (r_cnt == CW'(WIDTH - 1)) begin
              r_state <= S_FIX;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
          S_FIX: begin
            r_result <= {w_rem_fix, w_quot_fix};
            r_valid  <= 1'b1;
            r_state  <= S_DONE;
          end
          default: begin
            // DONE: the same instruction is still in EX, so start is ignored here.
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_div_iter.sv
// Directed testbench for div_iter with WIDTH=32.
// Expected results are hand-computed constants.
module tb_div_iter;

  logic        clk;
  logic        resetn;
  logic        start;
  logic        is_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        annul;
  logic        stall;
  logic        valid;
  logic [63:0] result;

  int total = 0;
  int bad   = 0;

  div_iter #(.WIDTH(32)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .start     (start),
    .is_signed (is_signed),
    .dividend  (dividend),
    .divisor   (divisor),
    .annul     (annul),
    .stall     (stall),
    .valid     (valid),
    .result    (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Runs one divide from the current cycle (cycle 0).
  // Execute holds start while stalled and drops it when DONE is reached.
  task automatic run_op(input string tag, input logic s, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp);
    start = 1'b1; is_signed = s; dividend = a; divisor = b;
    for (int c = 0; c <= 35; c++) begin
      #4;
      check({tag, " stall"}, 64'(stall), 64'(c <= 33));
      check({tag, " valid"}, 64'(valid), 64'(c == 34));
      if (c == 34) check({tag, " result"}, result, exp);
      @(posedge clk); #1;
      if (c == 33) start = 1'b0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0; start = 1'b0; is_signed = 1'b0;
    dividend = '0; divisor = '0; annul = 1'b0;
    #1;
    check("reset stall",  64'(stall), 64'd0);
    check("reset valid",  64'(valid), 64'd0);
    check("reset result", result,     64'd0);
    #11 resetn = 1'b1;
    @(posedge clk); #1;

    // DIVU 100 / 7 = 14 rem 2
    run_op("divu100/7", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14});
    // DIV -2^31 / -1: no special case; the quotient wraps to 0x8000_0000
    run_op("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000});
    // DIVU by zero: remainder = dividend, quotient = all ones
    run_op("divu_dz", 1'b0, 32'h1234_5678, 32'd0, {32'h1234_5678, 32'hFFFF_FFFF});

    // Annul in cycle 10: no valid, result keeps the previous value
    start = 1'b1; is_signed = 1'b0; dividend = 32'd100; divisor = 32'd7;
    for (int c = 0; c <= 11; c++) begin
      if (c == 10) annul = 1'b1;
      if (c == 11) begin annul = 1'b0; start = 1'b0; end
      #4;
      check("annul stall",  64'(stall), 64'(c <= 10));
      check("annul valid",  64'(valid), 64'd0);
      check("annul result", result, {32'h1234_5678, 32'hFFFF_FFFF});
      @(posedge clk); #1;
    end
    // A fresh DIVU 9 / 3 starting in cycle 12
    run_op("divu9/3", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3});

    // Reset in cycle 20 of an operation: the outputs clear immediately
    start = 1'b1; is_signed = 1'b0; dividend = 32'd1000; divisor = 32'd10;
    for (int c = 0; c <= 19; c++) begin
      #4;
      check("rst_mid stall_pre", 64'(stall), 64'd1);
      @(posedge clk); #1;
    end
    #2 resetn = 1'b0; start = 1'b0;
    #1;
    check("rst_mid stall",  64'(stall), 64'd0);
    check("rst_mid valid",  64'(valid), 64'd0);
    check("rst_mid result", result,     64'd0);
    #1 resetn = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1; #4;
      check("post_rst stall",  64'(stall), 64'd0);
      check("post_rst valid",  64'(valid), 64'd0);
      check("post_rst result", result,     64'd0);
    end
    @(posedge clk); #1;

    // Back-to-back: start is held through DONE. The second DIV is captured in the next IDLE.
    start = 1'b1; is_signed = 1'b1; dividend = 32'hFFFF_FFF9; divisor = 32'd2;
    for (int c = 0; c <= 71; c++) begin
      if (c == 35) begin dividend = 32'd7; divisor = 32'hFFFF_FFFE; end
      if (c == 69) start = 1'b0;
      #4;
      check("b2b stall", 64'(stall), 64'((c <= 33) || (c >= 35 && c <= 68)));
      check("b2b valid", 64'(valid), 64'(c == 34 || c == 69));
      if (c == 34) check("div-7/2 result", result, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
      if (c == 69) check("div7/-2 result", result, {32'h0000_0001, 32'hFFFF_FFFD});
      @(posedge clk); #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
